// File: rtl/plic_regfile_if.sv
// rtl/plic_regfile_if.sv - CPU register bus for the PLIC register front end
interface plic_regfile_if;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output addr, wdata, we, re,
        input  rdata, rvalid
    );

    modport slave (
        input  addr, wdata, we, re,
        output rdata, rvalid
    );
endinterface

// File: rtl/plic_regfile.sv
// rtl/plic_regfile.sv - PLIC configuration registers and claim/complete handshake
module plic_regfile #(
    parameter logic [2:0]  RST_THRESHOLD = 3'd0,
    parameter logic [14:0] RST_EL        = 15'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    plic_regfile_if.slave       bus,
    output logic [14:0]         el,
    output logic [14:0]         ie,
    output logic [44:0]         ipriority,
    output logic [2:0]          threshold,
    output logic                claim,
    output logic                complete,
    input  logic [3:0]          id,
    input  logic                ireq,
    output logic                ext_irq
);

    typedef enum logic {IDLE = 1'b0, CLAIMED = 1'b1} state_t;

    localparam logic [4:0] W_IE  = 5'h10;
    localparam logic [4:0] W_EL  = 5'h11;
    localparam logic [4:0] W_THR = 5'h12;
    localparam logic [4:0] W_CC  = 5'h13;

    state_t      state_q, state_d;
    logic [44:0] prio_q, prio_d;
    logic [14:0] ie_q, ie_d;
    logic [14:0] el_q, el_d;
    logic [2:0]  thr_q, thr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        complete_q, complete_d;
    logic [3:0]  claimed_id_q, claimed_id_d;

    logic [4:0]  word;
    logic        rd_en;
    logic        cc_rd;
    logic        cc_wr;
    logic        complete_hit;
    logic [31:0] rd_val;

    // A write wins over a simultaneous read, so the read strobe is masked here.
    assign word         = bus.addr[6:2];
    assign rd_en        = bus.re & ~bus.we;
    assign cc_rd        = rd_en & (word == W_CC);
    assign cc_wr        = bus.we & (word == W_CC);
    assign complete_hit = cc_wr & (state_q == CLAIMED) &
                          (bus.wdata == {28'd0, claimed_id_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cc_rd && (id != 4'd0)) state_d = CLAIMED;
            CLAIMED: if (complete_hit)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Claim is combinational so the core latches the same id the CPU reads back.
    always_comb begin
        claim   = cc_rd & (state_q == IDLE) & (id != 4'd0);
        ext_irq = ireq & (state_q == IDLE);
    end

    always_comb begin
        rd_val = 32'd0;
        for (int s = 0; s < 15; s++) begin
            if (word == 5'(s + 1)) rd_val = {29'd0, prio_q[3*s +: 3]};
        end
        case (word)
            W_IE:    rd_val = {17'd0, ie_q};
            W_EL:    rd_val = {17'd0, el_q};
            W_THR:   rd_val = {29'd0, thr_q};
            W_CC:    rd_val = claim ? {28'd0, id} : 32'd0;
            default: ;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        ie_d   = ie_q;
        el_d   = el_q;
        thr_d  = thr_q;
        if (bus.we) begin
            for (int s = 0; s < 15; s++) begin
                if (word == 5'(s + 1)) prio_d[3*s +: 3] = bus.wdata[2:0];
            end
            if (word == W_IE)  ie_d  = bus.wdata[14:0];
            if (word == W_EL)  el_d  = bus.wdata[14:0];
            if (word == W_THR) thr_d = bus.wdata[2:0];
        end
        rdata_d      = rd_en ? rd_val : rdata_q;
        rvalid_d     = rd_en;
        complete_d   = complete_hit;
        claimed_id_d = claim ? id : claimed_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q       <= '0;
            ie_q         <= '0;
            el_q         <= RST_EL;
            thr_q        <= RST_THRESHOLD;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            complete_q   <= 1'b0;
            claimed_id_q <= '0;
        end else begin
            prio_q       <= prio_d;
            ie_q         <= ie_d;
            el_q         <= el_d;
            thr_q        <= thr_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            complete_q   <= complete_d;
            claimed_id_q <= claimed_id_d;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign el         = el_q;
    assign ie         = ie_q;
    assign ipriority  = prio_q;
    assign threshold  = thr_q;
    assign complete   = complete_q;

endmodule

// File: tb/tb_plic_regfile.sv
// tb/tb_plic_regfile.sv - self-checking bench for plic_regfile
module tb_plic_regfile;
    localparam logic [2:0]  P_THR = 3'd1;
    localparam logic [14:0] P_EL  = 15'h00A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] el, ie;
    logic [44:0] ipriority;
    logic [2:0]  threshold;
    logic        claim, complete, ext_irq, ireq;
    logic [3:0]  id;

    int checks = 0;
    int failures = 0;

    plic_regfile_if bus();

    plic_regfile #(.RST_THRESHOLD(P_THR), .RST_EL(P_EL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .el(el), .ie(ie), .ipriority(ipriority), .threshold(threshold),
        .claim(claim), .complete(complete),
        .id(id), .ireq(ireq), .ext_irq(ext_irq)
    );

    always #5 clk = ~clk;

    // Reference model: register contents as plain arrays plus one busy flag.
    logic [2:0]  m_prio [1:15];
    logic [14:0] m_ie, m_el;
    logic [2:0]  m_thr;
    logic        m_busy;
    logic [3:0]  m_cid;
    logic        e_rvalid, e_complete;
    logic [31:0] e_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        if (a >= 4 && a <= 60) return {29'd0, m_prio[a / 4]};
        if (a == 64) return {17'd0, m_ie};
        if (a == 68) return {17'd0, m_el};
        if (a == 72) return {29'd0, m_thr};
        if (a == 76) return (!m_busy && id != 0) ? {28'd0, id} : 32'd0;
        return 32'd0;
    endfunction

    function automatic logic [44:0] model_flat();
        logic [44:0] f = '0;
        for (int s = 1; s <= 15; s++) f[3*(s-1) +: 3] = m_prio[s];
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 1; s <= 15; s++) m_prio[s] <= 3'd0;
            m_ie       <= '0;
            m_el       <= P_EL;
            m_thr      <= P_THR;
            m_busy     <= 1'b0;
            m_cid      <= '0;
            e_rvalid   <= 1'b0;
            e_complete <= 1'b0;
            e_rdata    <= '0;
        end else begin
            int a;
            a = int'({bus.addr[6:2], 2'b00});
            e_rvalid   <= bus.re && !bus.we;
            e_complete <= 1'b0;
            if (bus.we) begin
                if (a >= 4 && a <= 60) m_prio[a / 4] <= bus.wdata[2:0];
                if (a == 64) m_ie  <= bus.wdata[14:0];
                if (a == 68) m_el  <= bus.wdata[14:0];
                if (a == 72) m_thr <= bus.wdata[2:0];
                if (a == 76 && m_busy && bus.wdata == {28'd0, m_cid}) begin
                    e_complete <= 1'b1;
                    m_busy     <= 1'b0;
                end
            end else if (bus.re) begin
                e_rdata <= model_read(a);
                if (a == 76 && !m_busy && id != 0) begin
                    m_busy <= 1'b1;
                    m_cid  <= id;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ie", ie, m_ie);
            chk("el", el, m_el);
            chk("threshold", threshold, m_thr);
            chk("ipriority", ipriority, model_flat());
            chk("ext_irq", ext_irq, ireq && !m_busy);
            chk("claim", claim, bus.re && !bus.we && bus.addr[6:2] == 5'h13 && !m_busy && id != 0);
            chk("complete", complete, e_complete);
            chk("rvalid", bus.rvalid, e_rvalid);
            if (e_rvalid) chk("rdata", bus.rdata, e_rdata);
        end
    end

    task automatic acc(input logic w, input logic r, input logic [6:0] a, input logic [31:0] d);
        bus.we = w; bus.re = r; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.we = 1'b0; bus.re = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.wdata = '0;
        id = 4'd0; ireq = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        acc(0, 1, 7'h40, 0); chk("rst_ie_rd", bus.rdata, 32'h0); chk("rst_rvalid", bus.rvalid, 1);
        acc(0, 1, 7'h44, 0); chk("rst_el_rd", bus.rdata, 32'h00A5);
        acc(0, 1, 7'h48, 0); chk("rst_thr_rd", bus.rdata, 32'h1);
        acc(0, 1, 7'h04, 0); chk("rst_prio_rd", bus.rdata, 32'h0);
        @(posedge clk); #1 chk("rvalid_pulse", bus.rvalid, 0);

        acc(1, 0, 7'h0C, 32'hFFFF_FFFD); chk("prio3_out", ipriority[8:6], 3'd5);
        acc(1, 0, 7'h40, 32'hFFFF_0004); chk("ie_out", ie, 15'h0004);
        acc(1, 0, 7'h48, 32'hFFFF_FFFA); chk("thr_out", threshold, 3'd2);
        acc(0, 1, 7'h0C, 0); chk("prio3_rd", bus.rdata, 32'h5);
        acc(0, 1, 7'h40, 0); chk("ie_rd", bus.rdata, 32'h4);
        acc(1, 0, 7'h00, 32'hFFFF_FFFF);
        acc(0, 1, 7'h00, 0); chk("rsvd_rd", bus.rdata, 32'h0);
        acc(1, 0, 7'h50, 32'hFFFF_FFFF);
        acc(0, 1, 7'h50, 0); chk("unmapped_rd", bus.rdata, 32'h0);

        id = 4'd3; ireq = 1'b1;
        bus.re = 1'b1; bus.addr = 7'h4C;
        #2 chk("claim_hi", claim, 1);
        @(posedge clk); #1 bus.re = 1'b0;
        chk("claim_rd", bus.rdata, 32'h3); chk("claim_rvalid", bus.rvalid, 1);
        chk("claim_lo", claim, 0); chk("irq_gated", ext_irq, 0);
        bus.re = 1'b1;
        #2 chk("claim2_none", claim, 0);
        @(posedge clk); #1 bus.re = 1'b0;
        chk("claim2_rd", bus.rdata, 32'h0);

        acc(1, 0, 7'h4C, 32'h5);  chk("cmp_wrong", complete, 0); chk("still_claimed", ext_irq, 0);
        acc(1, 0, 7'h4C, 32'h13); chk("cmp_upper", complete, 0);
        acc(1, 0, 7'h4C, 32'h3);  chk("cmp_pulse", complete, 1); chk("irq_back", ext_irq, 1);
        @(posedge clk); #1 chk("cmp_single", complete, 0);
        acc(1, 0, 7'h4C, 32'h3);  chk("cmp_idle", complete, 0);

        id = 4'd0;
        acc(0, 1, 7'h4C, 0); chk("empty_rd", bus.rdata, 32'h0);
        acc(1, 1, 7'h48, 32'h7); chk("coll_thr", threshold, 3'd7); chk("coll_rvalid", bus.rvalid, 0);

        id = 4'd5;
        acc(0, 1, 7'h4C, 0); chk("claim5_rd", bus.rdata, 32'h5);
        rst_n = 1'b0;
        #2;
        chk("rst_claim", claim, 0); chk("rst_complete", complete, 0);
        chk("rst_rvalid2", bus.rvalid, 0); chk("rst_idle", ext_irq, 1);
        chk("rst_thr2", threshold, 3'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        id = 4'd2;
        bus.re = 1'b1; bus.addr = 7'h4C;
        #2 chk("reclaim_hi", claim, 1);
        @(posedge clk); #1 bus.re = 1'b0;
        chk("reclaim_rd", bus.rdata, 32'h2);
        acc(1, 0, 7'h4C, 32'h2); chk("reclaim_cmp", complete, 1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/plic_regfile.md
Name: plic_regfile

Overview:
- Memory-mapped register front end for the 15-source PLIC core.
- Holds the configuration registers that feed the core: per-source priority, interrupt enable, edge/level select and threshold.
- Converts CPU reads and writes of the claim/complete register into the core's single-cycle claim and complete strobes.
- Tracks the single outstanding claim and gates the hart-facing interrupt line while a claim is in service.

Parameters:
- RST_THRESHOLD, 3'd0: reset value of the threshold register.
- RST_EL, 15'h0000: reset value of the edge/level register; 1 = edge, 0 = level.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  7  byte address; addr[1:0] ignored
- wdata  in  32  write data
- we  in  1  write strobe, one cycle per access
- re  in  1  read strobe, one cycle per access
- rdata  out  32  registered read data
- rvalid  out  1  read data valid
- el  out  15  edge/level select to core
- ie  out  15  interrupt enable to core
- ipriority  out  45  priority of source s+1 in bits [3s+2:3s]
- threshold  out  3  priority threshold to core
- claim  out  1  claim strobe to core
- complete  out  1  complete strobe to core
- id  in  4  current best pending id from core; 0 = none
- ireq  in  1  request from core
- ext_irq  out  1  external interrupt to hart

Behaviour:
- Register map (word offsets):
  - 0x04..0x3C: priority of source n at 4*n, n = 1..15, bits [2:0].
  - 0x00: reserved; reads 0, writes ignored.
  - 0x40: ie[14:0].
  - 0x44: el[14:0].
  - 0x48: threshold[2:0].
  - 0x4C: claim/complete.
  - All other addresses read 0; writes to them are ignored. Unused bits read 0.
- Reset values: priorities 0, ie 0, el RST_EL, threshold RST_THRESHOLD, rdata 0, rvalid 0, claim 0, complete 0, state IDLE, claimed_id 0.
- Writes take effect at the clock edge that samples we. The new value appears on the config outputs in the following cycle.
- Reads: re sampled at edge T; rdata and rvalid are valid during T+1. rvalid is a single-cycle pulse.
- we and re asserted together: the write is performed and the read is dropped (rvalid stays 0, no claim).
- State machine:
  - IDLE -> CLAIMED on a claim read with id != 0.
  - CLAIMED -> IDLE on a matching complete write.
- Claim read (re, addr 0x4C):
  - In IDLE with id != 0: claim is driven combinationally high in the same cycle as re, so the core latches id on the same edge. rdata = id sampled at that edge. claimed_id <= id. State goes to CLAIMED.
  - In IDLE with id == 0: rdata = 0, no claim, state unchanged.
  - In CLAIMED: rdata = 0, no claim (single outstanding claim only).
  - re held for multiple cycles produces at most one claim.
- Complete write (we, addr 0x4C):
  - In CLAIMED with wdata[3:0] == claimed_id and wdata[31:4] == 0: complete is a registered 1-cycle pulse in T+1, and state returns to IDLE at the same edge.
  - Any other complete write (wrong id, any id while IDLE, or nonzero upper bits) is ignored.
- ext_irq = ireq & (state == IDLE), combinational.
- Configuration writes are accepted in both states.
- Reset asserted mid-claim: returns to IDLE immediately and clears all strobes. Any in-flight read is lost.

Test Plan:
- Reset values: after reset, read 0x40, 0x44, 0x48, 0x04 -> rdata 0, RST_EL, RST_THRESHOLD, 0; rvalid high exactly one cycle after each re.
- Config path: write 0x0C = 5, 0x40 = 0x0004, 0x48 = 2 -> ipriority[8:6] = 5, ie = 15'h0004, threshold = 2 one cycle after each we; readback masks to those widths; write to 0x00 reads back 0.
- Claim: id = 3, ireq = 1, read 0x4C -> claim high in the re cycle only; rdata = 3 with rvalid; ext_irq = 0 from the next cycle; a second read returns 0 with no claim.
- Complete: in CLAIMED with id 3, write 0x4C = 5 -> no complete, still CLAIMED; write 0x4C = 3 -> complete pulse one cycle later, IDLE, ext_irq follows ireq again.
- Empty and collision: id = 0, read 0x4C -> rdata 0, no claim. Simultaneous we = 1, re = 1 to 0x48 with wdata = 7 -> threshold = 7, rvalid stays 0.
- Reset mid-claim: in CLAIMED, pulse rst_n low -> claim, complete, rvalid = 0; IDLE; a fresh claim read with id = 2 succeeds.
